// File: rtl/fusion_ctrl.sv
// fusion_ctrl: job sequencer for one fusion_unit. Latches a job configuration,
// streams operand word pairs into the fusion unit, accumulates its psum and
// hands the dot-product result downstream over a valid/ready handshake.
module fusion_ctrl #(
  parameter int unsigned LEN_W = 8,
  parameter int unsigned ACC_W = 40
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic             start,
  input  logic             abort,
  input  logic [2:0]       cfg_input_bitwidth,
  input  logic [2:0]       cfg_weight_bitwidth,
  input  logic [3:0]       cfg_input_sign,
  input  logic [3:0]       cfg_weight_sign,
  input  logic [LEN_W-1:0] cfg_len,
  output logic             busy,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [31:0]      op_input,
  input  logic [31:0]      op_weight,
  output logic [2:0]       fu_input_bitwidth,
  output logic [2:0]       fu_weight_bitwidth,
  output logic [3:0]       fu_input_sign,
  output logic [3:0]       fu_weight_sign,
  output logic [31:0]      fu_input_forward,
  output logic [31:0]      fu_weight,
  input  logic [31:0]      fu_psum,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [2:0]       in_bw;
  logic [2:0]       wt_bw;
  logic [3:0]       in_sign;
  logic [3:0]       wt_sign;
  logic [LEN_W-1:0] cnt;
  logic [ACC_W-1:0] acc;

  logic             cfg_load;
  logic             acc_clr;
  logic             accept;
  logic [ACC_W-1:0] psum_ext;

  // fu_psum is a signed 32-bit quantity; widen it to the accumulator width.
  always_comb begin
    psum_ext = ACC_W'($signed(fu_psum));
  end

  // Next-state decode; abort dominates every other event in every state.
  always_comb begin
    state_nxt = state;
    cfg_load  = 1'b0;
    acc_clr   = 1'b0;
    accept    = 1'b0;
    if (abort) begin
      state_nxt = IDLE;
      acc_clr   = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            cfg_load  = 1'b1;
            acc_clr   = 1'b1;
            state_nxt = (cfg_len == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (op_valid) begin
            accept = 1'b1;
            if (cnt == LEN_W'(1)) begin
              state_nxt = DONE;
            end
          end
        end
        DONE: begin
          if (res_ready) begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Job configuration latched at start; drives the fusion unit for the whole job.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      in_bw   <= '0;
      wt_bw   <= '0;
      in_sign <= '0;
      wt_sign <= '0;
    end else if (cfg_load) begin
      in_bw   <= cfg_input_bitwidth;
      wt_bw   <= cfg_weight_bitwidth;
      in_sign <= cfg_input_sign;
      wt_sign <= cfg_weight_sign;
    end
  end

  // Remaining operand pair count; loaded at start, decremented per accept.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      cnt <= '0;
    end else if (cfg_load) begin
      cnt <= cfg_len;
    end else if (accept) begin
      cnt <= cnt - LEN_W'(1);
    end
  end

  // Wrapping two's-complement accumulator of fusion unit partial sums.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      acc <= '0;
    end else if (acc_clr) begin
      acc <= '0;
    end else if (accept) begin
      acc <= acc + psum_ext;
    end
  end

  // Handshake and status outputs decode from the registered state only;
  // abort is the single combinational qualifier so no pair is consumed then.
  always_comb begin
    op_ready  = (state == RUN) && !abort;
    busy      = (state != IDLE);
    res_valid = (state == DONE);
    res_data  = acc;
  end

  // Fusion unit feed: latched config plus operand words passed straight through.
  always_comb begin
    fu_input_bitwidth  = in_bw;
    fu_weight_bitwidth = wt_bw;
    fu_input_sign      = in_sign;
    fu_weight_sign     = wt_sign;
    fu_input_forward   = op_input;
    fu_weight          = op_weight;
  end

endmodule

// File: tb/tb_fusion_ctrl.sv
// tb_fusion_ctrl: scoreboard bench for fusion_ctrl with a behavioural fusion
// unit stand-in and a cycle model of the controller.
module tb_fusion_ctrl;

  localparam int unsigned LEN_W = 8;
  localparam int unsigned ACC_W = 40;

  logic             clk = 1'b0;
  logic             nRST;
  logic             start;
  logic             abort;
  logic [2:0]       cfg_input_bitwidth;
  logic [2:0]       cfg_weight_bitwidth;
  logic [3:0]       cfg_input_sign;
  logic [3:0]       cfg_weight_sign;
  logic [LEN_W-1:0] cfg_len;
  logic             busy;
  logic             op_valid;
  logic             op_ready;
  logic [31:0]      op_input;
  logic [31:0]      op_weight;
  logic [2:0]       fu_input_bitwidth;
  logic [2:0]       fu_weight_bitwidth;
  logic [3:0]       fu_input_sign;
  logic [3:0]       fu_weight_sign;
  logic [31:0]      fu_input_forward;
  logic [31:0]      fu_weight;
  logic [31:0]      fu_psum;
  logic             res_valid;
  logic             res_ready;
  logic [ACC_W-1:0] res_data;

  always #5 clk = ~clk;

  fusion_ctrl #(.LEN_W(LEN_W), .ACC_W(ACC_W)) dut (
    .clk                 (clk),
    .nRST                (nRST),
    .start               (start),
    .abort               (abort),
    .cfg_input_bitwidth  (cfg_input_bitwidth),
    .cfg_weight_bitwidth (cfg_weight_bitwidth),
    .cfg_input_sign      (cfg_input_sign),
    .cfg_weight_sign     (cfg_weight_sign),
    .cfg_len             (cfg_len),
    .busy                (busy),
    .op_valid            (op_valid),
    .op_ready            (op_ready),
    .op_input            (op_input),
    .op_weight           (op_weight),
    .fu_input_bitwidth   (fu_input_bitwidth),
    .fu_weight_bitwidth  (fu_weight_bitwidth),
    .fu_input_sign       (fu_input_sign),
    .fu_weight_sign      (fu_weight_sign),
    .fu_input_forward    (fu_input_forward),
    .fu_weight           (fu_weight),
    .fu_psum             (fu_psum),
    .res_valid           (res_valid),
    .res_ready           (res_ready),
    .res_data            (res_data)
  );

  // Fusion unit stand-in: a zero weight word passes the input word through as
  // psum (lets the bench force any psum); otherwise a 4-lane byte dot product
  // with per-lane signedness from the sign masks.
  function automatic logic [31:0] fu_model(logic [31:0] a, logic [31:0] w,
                                           logic [3:0] as, logic [3:0] ws);
    logic signed [31:0] sum;
    logic signed [8:0]  x;
    logic signed [8:0]  y;
    sum = '0;
    if (w == '0) return a;
    for (int i = 0; i < 4; i++) begin
      x = as[i] ? {a[8*i+7], a[8*i +: 8]} : {1'b0, a[8*i +: 8]};
      y = ws[i] ? {w[8*i+7], w[8*i +: 8]} : {1'b0, w[8*i +: 8]};
      sum = sum + x * y;
    end
    return sum;
  endfunction

  always_comb fu_psum = fu_model(fu_input_forward, fu_weight, fu_input_sign, fu_weight_sign);

  // Controller reference model and result scoreboard.
  typedef enum {M_IDLE, M_RUN, M_DONE} mstate_t;
  mstate_t          m_st;
  logic [LEN_W-1:0] m_cnt;
  logic [ACC_W-1:0] m_acc;
  logic [2:0]       m_ibw, m_wbw;
  logic [3:0]       m_is, m_ws;
  logic [ACC_W-1:0] exp_q[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st  = M_IDLE;
    m_cnt = '0;
    m_acc = '0;
    m_ibw = '0;
    m_wbw = '0;
    m_is  = '0;
    m_ws  = '0;
    exp_q.delete();
  endtask

  // One clock: called just after a negedge with inputs already driven.
  task automatic cycle();
    logic [31:0] p;
    #2;
    check("op_ready", 64'(op_ready), 64'(m_st == M_RUN && !abort));
    check("busy", 64'(busy), 64'(m_st != M_IDLE));
    check("res_valid", 64'(res_valid), 64'(m_st == M_DONE));
    check("fu_cfg", 64'({fu_input_bitwidth, fu_weight_bitwidth, fu_input_sign, fu_weight_sign}),
          64'({m_ibw, m_wbw, m_is, m_ws}));
    check("fu_operands", {fu_input_forward, fu_weight}, {op_input, op_weight});
    if (m_st == M_DONE) begin
      if (exp_q.size() == 0) check("scoreboard_underflow", 64'(exp_q.size()), 64'd1);
      else check("res_data", 64'(res_data), 64'(exp_q[0]));
    end
    p = fu_model(op_input, op_weight, m_is, m_ws);
    if (abort) begin
      if (m_st == M_DONE && exp_q.size() > 0) exp_q.delete(0);
      m_st  = M_IDLE;
      m_acc = '0;
    end else begin
      case (m_st)
        M_IDLE: if (start) begin
          m_ibw = cfg_input_bitwidth;
          m_wbw = cfg_weight_bitwidth;
          m_is  = cfg_input_sign;
          m_ws  = cfg_weight_sign;
          m_acc = '0;
          m_cnt = cfg_len;
          if (cfg_len == '0) begin
            m_st = M_DONE;
            exp_q.push_back(m_acc);
          end else begin
            m_st = M_RUN;
          end
        end
        M_RUN: if (op_valid) begin
          m_acc = m_acc + {{(ACC_W-32){p[31]}}, p};
          m_cnt = m_cnt - 1'b1;
          if (m_cnt == '0) begin
            m_st = M_DONE;
            exp_q.push_back(m_acc);
          end
        end
        M_DONE: if (res_ready) begin
          if (exp_q.size() > 0) exp_q.delete(0);
          m_st = M_IDLE;
        end
        default: m_st = M_IDLE;
      endcase
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic start_job(input logic [LEN_W-1:0] len, input logic [2:0] ibw, input logic [2:0] wbw,
                           input logic [3:0] is, input logic [3:0] ws);
    start               = 1'b1;
    cfg_len             = len;
    cfg_input_bitwidth  = ibw;
    cfg_weight_bitwidth = wbw;
    cfg_input_sign      = is;
    cfg_weight_sign     = ws;
    cycle();
    start               = 1'b0;
    cfg_len             = LEN_W'($urandom);
    cfg_input_bitwidth  = 3'($urandom);
    cfg_weight_bitwidth = 3'($urandom);
    cfg_input_sign      = 4'($urandom);
    cfg_weight_sign     = 4'($urandom);
  endtask

  task automatic finish_result(input int unsigned stall);
    op_valid  = 1'b0;
    res_ready = 1'b0;
    repeat (stall) cycle();
    res_ready = 1'b1;
    cycle();
    res_ready = 1'b0;
    cycle();
  endtask

  initial begin
    nRST = 1'b0; start = 1'b0; abort = 1'b0; op_valid = 1'b0; res_ready = 1'b0;
    op_input = '0; op_weight = '0; cfg_len = '0;
    cfg_input_bitwidth = '0; cfg_weight_bitwidth = '0; cfg_input_sign = '0; cfg_weight_sign = '0;
    model_reset();
    #1;
    check("rst_outputs", 64'({op_ready, busy, res_valid}), 64'd0);
    check("rst_res_data", 64'(res_data), 64'd0);
    check("rst_fu_cfg", 64'({fu_input_bitwidth, fu_weight_bitwidth, fu_input_sign, fu_weight_sign}), 64'd0);
    @(negedge clk);
    nRST = 1'b1;
    cycle();

    // Unsigned 8-bit job: four pairs of all-ones bytes, psum 4 each.
    start_job(8'd4, 3'd3, 3'd3, 4'h0, 4'h0);
    op_valid = 1'b1; op_input = 32'h0101_0101; op_weight = 32'h0101_0101;
    repeat (4) cycle();
    finish_result(0);

    // Signed wrap: two psums of 0x80000000.
    start_job(8'd2, 3'd5, 3'd1, 4'hF, 4'hF);
    op_valid = 1'b1; op_input = 32'h8000_0000; op_weight = '0;
    repeat (2) cycle();
    finish_result(1);

    // Backpressure: op_valid every other cycle, res_ready held off 5 cycles.
    start_job(8'd3, 3'd2, 3'd4, 4'b1010, 4'b0110);
    for (int i = 0; i < 6; i++) begin
      op_valid  = (i % 2 == 0);
      op_input  = $urandom;
      op_weight = $urandom | 32'h1;
      cycle();
    end
    finish_result(5);

    // Zero length job, plus start while already in DONE (ignored).
    start_job(8'd0, 3'd7, 3'd6, 4'h3, 4'hC);
    start = 1'b1; cfg_len = 8'd9;
    cycle();
    start = 1'b0;
    finish_result(1);

    // Abort on the third valid pair, then a one-pair job yielding 7.
    start_job(8'd5, 3'd3, 3'd3, 4'h1, 4'h2);
    op_valid = 1'b1; op_input = 32'h0203_0405; op_weight = 32'h0102_0304;
    repeat (2) cycle();
    abort = 1'b1;
    cycle();
    abort = 1'b0; op_valid = 1'b0;
    repeat (2) cycle();
    start_job(8'd1, 3'd1, 3'd1, 4'h0, 4'h0);
    op_valid = 1'b1; op_input = 32'd7; op_weight = '0;
    cycle();
    finish_result(0);

    // Abort beats start in IDLE and the result handshake in DONE.
    abort = 1'b1; start = 1'b1; cfg_len = 8'd2;
    cycle();
    abort = 1'b0; start = 1'b0;
    start_job(8'd1, 3'd2, 3'd2, 4'h0, 4'h0);
    op_valid = 1'b1; op_input = 32'hFFFF_FFF0; op_weight = '0;
    cycle();
    op_valid = 1'b0; res_ready = 1'b1; abort = 1'b1;
    cycle();
    abort = 1'b0; res_ready = 1'b0;
    cycle();

    // Reset mid-job: outputs drop at once, start is ignored while held.
    start_job(8'd4, 3'd4, 3'd5, 4'h6, 4'h9);
    op_valid = 1'b1; op_input = 32'h1122_3344; op_weight = 32'h0506_0708;
    cycle();
    #1;
    nRST = 1'b0; start = 1'b1; cfg_len = 8'd3;
    #1;
    check("nrst_outputs", 64'({op_ready, busy, res_valid}), 64'd0);
    check("nrst_res_data", 64'(res_data), 64'd0);
    check("nrst_fu_cfg", 64'({fu_input_bitwidth, fu_weight_bitwidth, fu_input_sign, fu_weight_sign}), 64'd0);
    @(posedge clk);
    #1;
    check("nrst_start_ignored", 64'({busy, op_ready}), 64'd0);
    @(negedge clk);
    #1;
    model_reset();
    start = 1'b0; op_valid = 1'b0; nRST = 1'b1;
    cycle();

    // Random signed job after reset.
    start_job(8'd3, 3'd3, 3'd3, 4'hF, 4'h5);
    for (int i = 0; i < 3; i++) begin
      op_valid = 1'b1; op_input = $urandom; op_weight = $urandom | 32'h100;
      cycle();
    end
    finish_result(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
